// File: rtl/uart_tx_cfg_if.sv
// Byte write port into the UART transmit FIFO.
// Valid/ready handshake; a byte moves on an edge with both high.
interface uart_tx_cfg_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmit path: write FIFO, baud divider and frame serializer.
// Frame format (5-8 bits, parity, 1/2 stops) is latched per frame.
module uart_tx_cfg #(
  parameter  int FIFO_DEPTH = 8,
  parameter  int BRD_W      = 16,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_cfg_if.slave     wr,
  input  logic             tx_en,
  input  logic [BRD_W-1:0] brd,
  input  logic [1:0]       cfg_bits,
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  input  logic             cfg_stop2,
  output logic             out_tx,
  output logic             busy,
  output logic             done,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BRD_W-1:0] baud_q, baud_d;
  logic [BRD_W-1:0] per_q, per_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bidx_q, bidx_d;
  logic [2:0]       nlast_q, nlast_d;
  logic             par_q, par_d;
  logic             par_en_q, par_en_d;
  logic             par_odd_q, par_odd_d;
  logic             stop2_q, stop2_d;
  logic             sidx_q, sidx_d;

  logic push;
  logic pop;
  logic load;
  logic tick;
  logic can_start;
  logic done_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_count = count_q;
  assign wr.wr_ready = ~fifo_full;

  // A full FIFO refuses writes even when a pop happens this cycle.
  assign push      = wr.wr_valid & ~fifo_full;
  assign can_start = tx_en & ~fifo_empty;
  assign tick      = (baud_q == per_q - BRD_W'(1));

  assign busy = (state_q != IDLE);
  assign done = done_d;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    per_d     = per_q;
    shift_d   = shift_q;
    bidx_d    = bidx_q;
    nlast_d   = nlast_q;
    par_d     = par_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    sidx_d    = sidx_q;
    load      = 1'b0;
    done_d    = 1'b0;

    if (state_q != IDLE) begin
      baud_d = tick ? '0 : baud_q + BRD_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (can_start) load = 1'b1;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          par_d   = par_q ^ shift_q[0];
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == nlast_q) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && !sidx_q) begin
            sidx_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (can_start) load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: pop the head and freeze the format for this frame.
    if (load) begin
      state_d   = START;
      shift_d   = mem[rptr_q];
      per_d     = (brd == '0) ? BRD_W'(1) : brd;
      nlast_d   = 3'd4 + {1'b0, cfg_bits};
      par_en_d  = cfg_par_en;
      par_odd_d = cfg_par_odd;
      stop2_d   = cfg_stop2;
      par_d     = 1'b0;
      baud_d    = '0;
      bidx_d    = '0;
      sidx_d    = 1'b0;
    end
  end

  assign pop = load;

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    out_tx = 1'b1;
    unique case (state_q)
      IDLE:    out_tx = 1'b1;
      START:   out_tx = 1'b0;
      DATA:    out_tx = shift_q[0];
      PARITY:  out_tx = par_q ^ par_odd_q;
      STOP:    out_tx = 1'b1;
      default: out_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= wr.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      per_q     <= BRD_W'(1);
      shift_q   <= '0;
      bidx_q    <= '0;
      nlast_q   <= 3'd7;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      sidx_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      baud_q    <= baud_d;
      per_q     <= per_d;
      shift_q   <= shift_d;
      bidx_q    <= bidx_d;
      nlast_q   <= nlast_d;
      par_q     <= par_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      sidx_q    <= sidx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg.
// Line levels per bit period are hand-encoded, bit i = period i.
module tb_uart_tx_cfg;

  logic        clk;
  logic        rst;
  logic        tx_en;
  logic [15:0] brd;
  logic [1:0]  cfg_bits;
  logic        cfg_par_en;
  logic        cfg_par_odd;
  logic        cfg_stop2;
  logic        out_tx;
  logic        busy;
  logic        done;
  logic        fifo_empty;
  logic        fifo_full;
  logic [3:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  uart_tx_cfg_if wr_if ();

  uart_tx_cfg dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr_if),
    .tx_en       (tx_en),
    .brd         (brd),
    .cfg_bits    (cfg_bits),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .cfg_stop2   (cfg_stop2),
    .out_tx      (out_tx),
    .busy        (busy),
    .done        (done),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = b;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag,
                             input logic [15:0] lv,
                             input int nper,
                             input int per);
    int last;
    last = nper * per - 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      chk({tag, "_tx"}, 32'(out_tx), 32'(lv[k/per]));
      chk({tag, "_done"}, 32'(done), 32'(k == last));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    tx_en = 1'b0;
    brd = 16'd1;
    cfg_bits = 2'd3;
    cfg_par_en = 1'b0;
    cfg_par_odd = 1'b0;
    cfg_stop2 = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(out_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_rdy", 32'(wr_if.wr_ready), 32'd1);
    rst = 1'b0;

    // 8N1 at 4 clocks per bit, 0xA5
    brd = 16'd4;
    tx_en = 1'b1;
    send(8'hA5);
    chk("t1_empty", 32'(fifo_empty), 32'd0);
    chk("t1_pre_tx", 32'(out_tx), 32'd1);
    chk("t1_pre_busy", 32'(busy), 32'd0);
    check_frame("t1", 16'h034A, 10, 4);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_tx", 32'(out_tx), 32'd1);
    chk("t1_idle_empty", 32'(fifo_empty), 32'd1);

    // 7E2 at 2 clocks per bit, 0x55
    brd = 16'd2;
    cfg_bits = 2'd2;
    cfg_par_en = 1'b1;
    cfg_par_odd = 1'b0;
    cfg_stop2 = 1'b1;
    send(8'h55);
    check_frame("t2", 16'h06AA, 11, 2);

    // 5O1, divisor 0 and 1 must match
    brd = 16'd0;
    cfg_bits = 2'd0;
    cfg_par_odd = 1'b1;
    cfg_stop2 = 1'b0;
    send(8'h1F);
    check_frame("t3a", 16'h00BE, 8, 1);
    brd = 16'd1;
    send(8'h1F);
    check_frame("t3b", 16'h00BE, 8, 1);

    // fill past full with tx disabled
    cfg_bits = 2'd3;
    cfg_par_en = 1'b0;
    cfg_par_odd = 1'b0;
    tx_en = 1'b0;
    @(negedge clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data = 8'd1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t4_cnt", 32'(fifo_count), (i < 8) ? 32'(i + 1) : 32'd8);
      chk("t4_rdy", 32'(wr_if.wr_ready), (i < 7) ? 32'd1 : 32'd0);
      wr_if.wr_data = 8'(i + 2);
    end
    wr_if.wr_valid = 1'b0;
    chk("t4_full", 32'(fifo_full), 32'd1);
    tx_en = 1'b1;
    for (int b = 1; b <= 8; b++) begin
      check_frame("t4", 16'({1'b1, 8'(b), 1'b0}), 10, 1);
    end
    @(negedge clk);
    chk("t4_end_busy", 32'(busy), 32'd0);
    chk("t4_end_empty", 32'(fifo_empty), 32'd1);
    chk("t4_end_cnt", 32'(fifo_count), 32'd0);

    // push and pop together at count 3
    tx_en = 1'b0;
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    chk("t5_cnt3", 32'(fifo_count), 32'd3);
    tx_en = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data = 8'h11;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    tx_en = 1'b0;
    chk("t5_pp_cnt", 32'(fifo_count), 32'd3);
    chk("t5_pp_busy", 32'(busy), 32'd1);
    repeat (12) @(negedge clk);
    chk("t5_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) send(8'(8'hB0 + i));
    chk("t5_cnt8", 32'(fifo_count), 32'd8);
    chk("t5_rdy0", 32'(wr_if.wr_ready), 32'd0);
    tx_en = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data = 8'h22;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    tx_en = 1'b0;
    chk("t5_rej_cnt", 32'(fifo_count), 32'd7);
    chk("t5_rej_rdy", 32'(wr_if.wr_ready), 32'd1);

    // reset in the middle of a data bit
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_tx", 32'(out_tx), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_cnt", 32'(fifo_count), 32'd0);
    chk("t6_rst_empty", 32'(fifo_empty), 32'd1);
    rst = 1'b0;
    brd = 16'd3;
    tx_en = 1'b1;
    send(8'h3C);
    check_frame("t6", 16'h0278, 10, 3);
    @(negedge clk);
    chk("t6_end_busy", 32'(busy), 32'd0);
    chk("t6_end_empty", 32'(fifo_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised next-generation UART transmit path: write-side FIFO, baud-rate divider and frame serializer in one block. Frame format is runtime-configurable: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits. Sits between the LSU memory-mapped UART registers and the pad. Uses a valid/ready write port with backpressure instead of separate load/enable strobes.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of two, 2..256
BRD_W, 16, width of the baud divisor input
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived, not overridable)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_valid  in  1  write request
wr_data  in  8  byte to send; bits above the configured length are ignored
wr_ready  out  1  equals !fifo_full; write accepted on an edge where wr_valid & wr_ready
tx_en  in  1  allows a new frame to start; does not abort a frame in progress
brd  in  BRD_W  clocks per bit; 0 is treated as 1
cfg_bits  in  2  data length: 0=5, 1=6, 2=7, 3=8
cfg_par_en  in  1  parity bit present
cfg_par_odd  in  1  1=odd, 0=even parity
cfg_stop2  in  1  1=two stop bits
out_tx  out  1  serial line, idles high
busy  out  1  high from START through the last stop bit
done  out  1  one-cycle pulse on the last cycle of the final stop bit
fifo_empty  out  1  FIFO empty
fifo_full  out  1  FIFO full
fifo_count  out  CNT_W  entries held, 0..FIFO_DEPTH

Behaviour:
- Reset: out_tx=1, busy=0, done=0, fifo_count=0, fifo_empty=1, fifo_full=0, FSM=IDLE, baud counter=0. FIFO pointers are cleared.
- Reset mid-frame aborts the frame. out_tx is 1 from the cycle after the reset edge.
- FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH.
  - wr_ready=!fifo_full. There is no write-through when full, even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves the count unchanged.
  - A write when not ready is dropped, with no state change.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when tx_en & !fifo_empty. On that edge: pop the head into the shift register, latch brd/cfg_* into frame-local registers, clear the baud counter, clear the parity accumulator.
  - Config changes mid-frame have no effect on the current frame.
- Bit timing: each state bit lasts max(brd,1) clocks. The baud counter counts 0..max(brd,1)-1, and a bit boundary occurs when it reaches max-1.
- Line levels:
  - START: out_tx=0.
  - DATA: LSB first, N=5..8 bits per cfg_bits. Bit index counter 0..N-1, parity XOR accumulated per bit.
  - PARITY (only if par_en): out_tx = XOR of data bits ^ par_odd.
  - STOP: out_tx=1 for 1 or 2 bit periods.
- Transitions:
  - DATA -> PARITY if par_en, else -> STOP.
  - STOP -> IDLE after the last stop period.
  - If tx_en & !fifo_empty at that boundary: go directly to START (back-to-back frames, no idle gap) and pop/latch as above.
- done asserts on the last clock of the last stop bit, in both the back-to-back and the idle case.
- busy=1 in every state except IDLE.
- Latency: byte accepted on edge E into an empty FIFO with FSM IDLE and tx_en=1. fifo_empty falls after E; the pop occurs on E+1; out_tx falls after E+1.
- Frame length in clocks: max(brd,1) * (1 + N + par_en + 1 + stop2).
- tx_en deasserted mid-frame: the current frame completes; no new frame starts until tx_en=1.

Test Plan:
- brd=4, 8N1, write 0xA5 -> out_tx 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; 40 clocks total. done pulses on clock 40. busy high for clocks 1-40.
- brd=2, 7E2 (cfg_bits=2, par_en=1, odd=0, stop2=1), write 0x55 -> data 1,0,1,0,1,0,1; parity 0; stops 1,1. 22-clock frame.
- brd=0 vs brd=1, 5O1, write 0x1F -> identical waveforms: 1 clock per bit; data 11111; parity 0 (odd). 8-clock frame.
- tx_en=0, write FIFO_DEPTH+1 bytes -> wr_ready falls after the 8th accept; the 9th byte is dropped; fifo_count=8. Then tx_en=1 -> 8 back-to-back frames with no idle cycle between them and 8 done pulses; fifo_empty=1 at the end.
- Simultaneous push and pop at count 3 -> count stays 3. Write at count 8 with a simultaneous pop -> write rejected, count becomes 7.
- Assert rst during a DATA bit -> next cycle out_tx=1, busy=0, fifo_count=0. Then send 0x3C -> correct frame with no residue from the aborted one.
